// File: rtl/div_bus_pkg.sv
// Shared types and constants for the divider register-interface bus master.
// Address map: X operand, Y operand, quotient readback.
package div_bus_pkg;

  localparam int DEF_DATA_W = 16;

  localparam logic [1:0] ADDR_X = 2'd0;
  localparam logic [1:0] ADDR_Y = 2'd1;
  localparam logic [1:0] ADDR_Q = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_X = 3'd1,
    WR_Y = 3'd2,
    RD   = 3'd3,
    WAIT = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/div_bus_master.sv
// Bus initiator for the divider peripheral: takes one X/Y request, writes both
// operands, reads the quotient back and returns it over a valid/ready port.
module div_bus_master
  import div_bus_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [DATA_W-1:0] REQ_X,
  input  logic [DATA_W-1:0] REQ_Y,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_Q,
  output logic              RSP_ERR,
  output logic [DATA_W-1:0] BUS_D,
  output logic [1:0]        BUS_ADDR,
  output logic              BUS_W,
  output logic              BUS_R,
  output logic              BUS_E,
  input  logic [31:0]       BUS_OUT
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t             state;
  logic [DATA_W-1:0]  y_op;
  logic [CNT_W-1:0]   cnt;

  // Upper read-data bits carry nothing for a DATA_W-wide divider.
  logic unused_bus_hi;
  assign unused_bus_hi = ^BUS_OUT[31:DATA_W];

  // X goes straight into BUS_D on acceptance, so only Y needs its own latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      y_op      <= '0;
      cnt       <= '0;
      REQ_READY <= 1'b1;
      RSP_VALID <= 1'b0;
      RSP_Q     <= '0;
      RSP_ERR   <= 1'b0;
      BUS_D     <= '0;
      BUS_ADDR  <= ADDR_X;
      BUS_W     <= 1'b0;
      BUS_R     <= 1'b0;
      BUS_E     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID && REQ_READY) begin
            y_op      <= REQ_Y;
            REQ_READY <= 1'b0;
            if (REQ_Y == '0) begin
              state     <= DONE;
              RSP_Q     <= '1;
              RSP_ERR   <= 1'b1;
              RSP_VALID <= 1'b1;
            end else begin
              state    <= WR_X;
              BUS_E    <= 1'b1;
              BUS_W    <= 1'b1;
              BUS_ADDR <= ADDR_X;
              BUS_D    <= REQ_X;
            end
          end
        end
        WR_X: begin
          state    <= WR_Y;
          BUS_ADDR <= ADDR_Y;
          BUS_D    <= y_op;
          BUS_W    <= 1'b1;
        end
        WR_Y: begin
          state    <= RD;
          BUS_ADDR <= ADDR_Q;
          BUS_W    <= 1'b0;
          BUS_R    <= 1'b1;
        end
        RD: begin
          state <= WAIT;
          BUS_R <= 1'b0;
          cnt   <= CNT_W'(RD_LAT - 1);
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= DONE;
            RSP_Q     <= BUS_OUT[DATA_W-1:0];
            RSP_ERR   <= 1'b0;
            RSP_VALID <= 1'b1;
            BUS_E     <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (RSP_READY) begin
            state     <= IDLE;
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_bus_master.sv
// Directed bench for div_bus_master with a behavioural divider peripheral.
module tb_div_bus_master;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        REQ_VALID = 1'b0;
  logic        REQ_READY;
  logic [15:0] REQ_X = '0;
  logic [15:0] REQ_Y = '0;
  logic        RSP_VALID;
  logic        RSP_READY = 1'b0;
  logic [15:0] RSP_Q;
  logic        RSP_ERR;
  logic [15:0] BUS_D;
  logic [1:0]  BUS_ADDR;
  logic        BUS_W;
  logic        BUS_R;
  logic        BUS_E;
  logic [31:0] BUS_OUT = '0;

  int checks = 0;
  int errors = 0;

  localparam logic [39:0] RESET_OUTS = {1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0};

  div_bus_master #(.DATA_W(16), .RD_LAT(1)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_X(REQ_X), .REQ_Y(REQ_Y),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_Q(RSP_Q), .RSP_ERR(RSP_ERR),
    .BUS_D(BUS_D), .BUS_ADDR(BUS_ADDR), .BUS_W(BUS_W), .BUS_R(BUS_R), .BUS_E(BUS_E),
    .BUS_OUT(BUS_OUT)
  );

  always #5 CLK = ~CLK;

  // Divider peripheral; junk in the upper half must be ignored by the master.
  logic [15:0] px = '0, py = '0;
  always @(posedge CLK) begin
    if (BUS_E && BUS_W && BUS_ADDR == 2'd0) px <= BUS_D;
    if (BUS_E && BUS_W && BUS_ADDR == 2'd1) py <= BUS_D;
    if (BUS_E && BUS_R && BUS_ADDR == 2'd2)
      BUS_OUT <= {16'hA5A5, (py != 0) ? px / py : 16'hFFFF};
  end

  logic [1:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  logic [1:0]  rd_addr[$];
  bit          overlap_seen = 1'b0;
  always @(negedge CLK) begin
    if (BUS_W) begin wr_addr.push_back(BUS_ADDR); wr_data.push_back(BUS_D); end
    if (BUS_R) rd_addr.push_back(BUS_ADDR);
    if (BUS_W && BUS_R) overlap_seen = 1'b1;
  end

  function automatic logic [39:0] outs();
    return {REQ_READY, RSP_VALID, RSP_Q, RSP_ERR, BUS_D, BUS_ADDR, BUS_W, BUS_R, BUS_E};
  endfunction

  task automatic clear_mon();
    wr_addr.delete(); wr_data.delete(); rd_addr.delete();
  endtask

  // Offers a request, waits for acceptance, then returns edges from acceptance to RSP_VALID.
  task automatic send(input logic [15:0] x, input logic [15:0] y, output int lat);
    int n;
    REQ_X = x; REQ_Y = y; REQ_VALID = 1'b1;
    n = 0;
    while (!REQ_READY && n < 20) begin @(posedge CLK); #1; n++; end
    if (!REQ_READY) begin errors++; $display("[TB] FAIL accept_timeout ready=%b required=1", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0; REQ_X = 16'hDEAD; REQ_Y = 16'h0000;
    lat = 0;
    while (!RSP_VALID && lat < 20) begin @(posedge CLK); #1; lat++; end
  endtask

  task automatic consume();
    RSP_READY = 1'b1;
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (outs() !== RESET_OUTS) begin errors++; $display("[TB] FAIL reset_outputs got=%h required=%h", outs(), RESET_OUTS); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    int lat;
    clear_mon();
    send(16'd100, 16'd1, lat);
    checks++; if (lat !== 4) begin errors++; $display("[TB] FAIL basic_latency got=%0d required=4", lat); end
    checks++; if (RSP_Q !== 16'd100) begin errors++; $display("[TB] FAIL basic_q got=%0d required=100", RSP_Q); end
    checks++; if (RSP_ERR !== 1'b0) begin errors++; $display("[TB] FAIL basic_err got=%b required=0", RSP_ERR); end
    checks++; if (BUS_E !== 1'b0) begin errors++; $display("[TB] FAIL basic_bus_e_done got=%b required=0", BUS_E); end
    checks++;
    if (wr_addr.size() != 2 || wr_addr[0] !== 2'd0 || wr_data[0] !== 16'd100 || wr_addr[1] !== 2'd1 || wr_data[1] !== 16'd1)
      begin errors++; $display("[TB] FAIL basic_writes got=%0d writes required=2 (0:100, 1:1)", wr_addr.size()); end
    checks++;
    if (rd_addr.size() != 1 || rd_addr[0] !== 2'd2)
      begin errors++; $display("[TB] FAIL basic_read got=%0d reads required=1 at addr 2", rd_addr.size()); end
    consume();
    checks++;
    if ({RSP_VALID, REQ_READY, RSP_Q} !== {1'b0, 1'b1, 16'd100})
      begin errors++; $display("[TB] FAIL basic_after_consume got=%b/%b/%0d required=0/1/100", RSP_VALID, REQ_READY, RSP_Q); end
  endtask

  task automatic test_small_quotient();
    int lat;
    clear_mon();
    send(16'd2, 16'd4, lat);
    checks++;
    if ({RSP_Q, RSP_ERR} !== {16'd0, 1'b0}) begin errors++; $display("[TB] FAIL small_q got=%0d/%b required=0/0", RSP_Q, RSP_ERR); end
    checks++;
    if (wr_addr.size() != 2 || rd_addr.size() != 1)
      begin errors++; $display("[TB] FAIL small_pulses got=%0d/%0d required=2/1", wr_addr.size(), rd_addr.size()); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lows;
    logic [15:0] q_seen;
    q_seen = '0;
    REQ_X = 16'hFFFF; REQ_Y = 16'hFFFF; REQ_VALID = 1'b1; RSP_READY = 1'b1;
    @(posedge CLK); #1;
    lows = 0;
    while (!REQ_READY && lows < 20) begin
      if (RSP_VALID) q_seen = RSP_Q;
      lows++;
      @(posedge CLK); #1;
    end
    checks++; if (lows !== 5) begin errors++; $display("[TB] FAIL b2b_ready_low got=%0d cycles required=5", lows); end
    checks++; if (q_seen !== 16'd1) begin errors++; $display("[TB] FAIL b2b_q1 got=%0d required=1", q_seen); end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    checks++; if (REQ_READY !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_accept got=%b required=0", REQ_READY); end
    lows = 0;
    while (!REQ_READY && lows < 20) begin @(posedge CLK); #1; lows++; end
    checks++; if (RSP_Q !== 16'd1 || !REQ_READY) begin errors++; $display("[TB] FAIL b2b_q2 got=%0d required=1", RSP_Q); end
    RSP_READY = 1'b0;
  endtask

  task automatic test_div_zero();
    int lat;
    clear_mon();
    send(16'd7, 16'd0, lat);
    checks++; if (lat !== 0) begin errors++; $display("[TB] FAIL dz_latency got=%0d required=0 extra edges", lat); end
    checks++;
    if ({RSP_Q, RSP_ERR} !== {16'hFFFF, 1'b1}) begin errors++; $display("[TB] FAIL dz_result got=%h/%b required=ffff/1", RSP_Q, RSP_ERR); end
    checks++;
    if (wr_addr.size() != 0 || rd_addr.size() != 0 || BUS_E !== 1'b0)
      begin errors++; $display("[TB] FAIL dz_no_bus got=%0d/%0d/%b required=0/0/0", wr_addr.size(), rd_addr.size(), BUS_E); end
    consume();
  endtask

  task automatic test_stall();
    int lat;
    bit bad;
    bad = 1'b0;
    send(16'd50, 16'd5, lat);
    repeat (5) begin
      if (RSP_VALID !== 1'b1 || RSP_Q !== 16'd10 || RSP_ERR !== 1'b0 || REQ_READY !== 1'b0) bad = 1'b1;
      @(posedge CLK); #1;
    end
    checks++;
    if (bad) begin errors++; $display("[TB] FAIL stall_hold got=%b/%0d/%b required=1/10/0", RSP_VALID, RSP_Q, REQ_READY); end
    consume();
    checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("[TB] FAIL stall_release got=%b required=0", RSP_VALID); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    REQ_X = 16'd9; REQ_Y = 16'd3; REQ_VALID = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({BUS_W, BUS_ADDR} !== {1'b1, 2'd1}) begin errors++; $display("[TB] FAIL mid_in_wr_y got=%b/%0d required=1/1", BUS_W, BUS_ADDR); end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checks++;
    if (outs() !== RESET_OUTS) begin errors++; $display("[TB] FAIL mid_reset_outputs got=%h required=%h", outs(), RESET_OUTS); end
    seen = 1'b0;
    repeat (8) begin @(posedge CLK); #1; if (RSP_VALID) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("[TB] FAIL mid_no_response got=1 required=0"); end
    send(16'd9, 16'd3, lat);
    checks++; if (RSP_Q !== 16'd3 || lat !== 4) begin errors++; $display("[TB] FAIL mid_retry_q got=%0d lat=%0d required=3 lat=4", RSP_Q, lat); end
    consume();
  endtask

  task automatic test_no_overlap();
    checks++;
    if (overlap_seen) begin errors++; $display("[TB] FAIL strobe_overlap got=1 required=0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_small_quotient();
    test_back_to_back();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
